// File: rtl/adder16_seq_ctrl.sv
// rtl/adder16_seq_ctrl.sv - nibble-serial adder/subtractor built around one 4-bit full adder
//
// fulladder_4b: combinational 4-bit adder
//   A, B   : nibble operands
//   Cex    : carry in
//   S      : nibble sum
//   CO     : carry out
//
// adder16_seq_ctrl: computes A+B+CIN or A-B one nibble per clock, LSB nibble first
//   CLK    : clock, rising edge
//   RST_n  : asynchronous active-low reset
//   START  : begin an operation (accepted in IDLE and FIN)
//   OP_A   : operand A, latched on accept
//   OP_B   : operand B, latched on accept
//   CIN    : carry in for add mode, latched on accept
//   SUB    : 1 = A minus B, 0 = A plus B plus CIN, latched on accept
//   SUM    : result (partial nibbles visible while BUSY)
//   COUT   : final carry (subtract: 1 = no borrow)
//   OVF    : signed overflow
//   BUSY   : nibbles being computed
//   DONE   : one-cycle pulse, SUM/COUT/OVF valid

module fulladder_4b (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cex,
    output logic [3:0] S,
    output logic       CO
);
    assign {CO, S} = {1'b0, A} + {1'b0, B} + {4'b0000, Cex};
endmodule

module adder16_seq_ctrl #(
    parameter int NIB = 4
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              START,
    input  logic [4*NIB-1:0]  OP_A,
    input  logic [4*NIB-1:0]  OP_B,
    input  logic              CIN,
    input  logic              SUB,
    output logic [4*NIB-1:0]  SUM,
    output logic              COUT,
    output logic              OVF,
    output logic              BUSY,
    output logic              DONE
);
    localparam int W  = 4 * NIB;
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;     // already inverted for subtract
    logic            carry;

    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [3:0]      s_nib;
    logic            co;
    logic [W-1:0]    sum_ins;
    logic            last;

    always_comb begin
        a_nib   = 4'h0;
        b_nib   = 4'h0;
        sum_ins = SUM;
        for (int i = 0; i < NIB; i++) begin
            if (idx == IW'(i)) begin
                a_nib            = a_reg[4*i +: 4];
                b_nib            = b_reg[4*i +: 4];
                sum_ins[4*i +: 4] = s_nib;
            end
        end
    end

    assign last = (idx == IW'(NIB - 1));

    fulladder_4b u_fa (
        .A   (a_nib),
        .B   (b_nib),
        .Cex (carry),
        .S   (s_nib),
        .CO  (co)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
            idx   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            SUM   <= '0;
            COUT  <= 1'b0;
            OVF   <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    DONE <= 1'b0;
                    if (START) begin
                        a_reg <= OP_A;
                        b_reg <= SUB ? ~OP_B : OP_B;
                        carry <= SUB ? 1'b1 : CIN;
                        SUM   <= '0;
                        idx   <= '0;
                        BUSY  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    SUM   <= sum_ins;
                    carry <= co;
                    if (last) begin
                        COUT  <= co;
                        // s_nib[3] is result bit W-1 on the last nibble
                        OVF   <= (a_reg[W-1] == b_reg[W-1]) && (s_nib[3] != a_reg[W-1]);
                        idx   <= '0;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= FIN;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder16_seq_ctrl.sv
// tb/tb_adder16_seq_ctrl.sv - self-checking bench for adder16_seq_ctrl

module tb_adder16_seq_ctrl;
    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        START = 1'b0;
    logic [15:0] OP_A = '0;
    logic [15:0] OP_B = '0;
    logic        CIN = 1'b0;
    logic        SUB = 1'b0;
    logic [15:0] SUM;
    logic        COUT, OVF, BUSY, DONE;

    logic        start1 = 1'b0;
    logic [3:0]  a1 = '0;
    logic [3:0]  b1 = '0;
    logic        cin1 = 1'b0;
    logic        sub1 = 1'b0;
    logic [3:0]  sum1;
    logic        cout1, ovf1, busy1, done1;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    adder16_seq_ctrl #(.NIB(4)) dut (
        .CLK(CLK), .RST_n(RST_n), .START(START), .OP_A(OP_A), .OP_B(OP_B),
        .CIN(CIN), .SUB(SUB), .SUM(SUM), .COUT(COUT), .OVF(OVF),
        .BUSY(BUSY), .DONE(DONE)
    );

    adder16_seq_ctrl #(.NIB(1)) dut1 (
        .CLK(CLK), .RST_n(RST_n), .START(start1), .OP_A(a1), .OP_B(b1),
        .CIN(cin1), .SUB(sub1), .SUM(sum1), .COUT(cout1), .OVF(ovf1),
        .BUSY(busy1), .DONE(done1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted operation is a plain 17-bit sum that
    // appears NIB clocks later; outputs hold until the next accept.
    int          m_cnt = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_sum = '0;
    logic        m_cout = 1'b0;
    logic        m_ovf = 1'b0;
    logic [15:0] e_sum = '0;
    logic        e_cout = 1'b0;
    logic        e_ovf = 1'b0;

    always @(posedge CLK or negedge RST_n) begin
        logic [15:0] beff;
        logic [16:0] full;
        if (!RST_n) begin
            m_cnt = 0; m_done = 0; m_sum = 0; m_cout = 0; m_ovf = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_done = 1; m_sum = e_sum; m_cout = e_cout; m_ovf = e_ovf;
            end
        end else begin
            m_done = 0;
            if (START) begin
                beff   = SUB ? ~OP_B : OP_B;
                full   = {1'b0, OP_A} + {1'b0, beff} + {16'b0, (SUB ? 1'b1 : CIN)};
                e_sum  = full[15:0];
                e_cout = full[16];
                e_ovf  = (OP_A[15] == beff[15]) && (full[15] != OP_A[15]);
                m_sum  = 16'h0;
                m_cnt  = 4;
            end
        end
    end

    always @(negedge CLK) begin
        if (RST_n) begin
            check("cmp_busy", BUSY, (m_cnt > 0));
            check("cmp_done", DONE, m_done);
            if (m_cnt == 0) begin
                check("cmp_sum", SUM, m_sum);
                check("cmp_cout", COUT, m_cout);
                check("cmp_ovf", OVF, m_ovf);
            end
        end
    end

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic s, output int lat, output int nbusy);
        @(negedge CLK);
        OP_A = a; OP_B = b; CIN = c; SUB = s; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        OP_A = 16'($urandom); OP_B = 16'($urandom); CIN = 1'($urandom); SUB = 1'($urandom);
        lat = 0; nbusy = 0;
        while (!DONE && lat < 40) begin
            if (BUSY) nbusy++;
            @(negedge CLK);
            lat++;
        end
        if (!DONE) check("done_timeout", 0, 1);
    endtask

    initial begin
        int lat, nb, gap;

        repeat (3) @(negedge CLK);
        check("rst_sum", SUM, 0);
        check("rst_flags", {COUT, OVF, BUSY, DONE}, 0);
        RST_n = 1'b1;

        do_op(16'h1234, 16'h4321, 0, 0, lat, nb);
        check("r030_lat", lat, 4);
        check("r030_busy", nb, 4);
        check("r030_sum", SUM, 16'h5555);
        check("r030_cout", COUT, 0);
        check("r030_ovf", OVF, 0);

        do_op(16'hFFFF, 16'h0001, 0, 0, lat, nb);
        check("r031a", {COUT, OVF, SUM}, {2'b10, 16'h0000});
        do_op(16'h7FFF, 16'h0001, 0, 0, lat, nb);
        check("r031b", {COUT, OVF, SUM}, {2'b01, 16'h8000});
        do_op(16'h0005, 16'h0007, 1, 1, lat, nb);
        check("r032a", {COUT, OVF, SUM}, {2'b00, 16'hFFFE});
        do_op(16'h8000, 16'h0001, 0, 1, lat, nb);
        check("r032b", {COUT, OVF, SUM}, {2'b11, 16'h7FFF});

        // START pulse at IDX=1 must be ignored
        @(negedge CLK);
        OP_A = 16'h1111; OP_B = 16'h2222; CIN = 0; SUB = 0; START = 1;
        @(negedge CLK); START = 0;
        @(negedge CLK); START = 1; OP_A = 16'hAAAA; OP_B = 16'h5555;
        @(negedge CLK); START = 0;
        lat = 0;
        while (!DONE && lat < 40) begin @(negedge CLK); lat++; end
        check("r033_ignore", SUM, 16'h3333);
        @(negedge CLK);
        check("r033_nodone", {BUSY, DONE}, 0);

        // START held through FIN: back-to-back, DONE 5 cycles apart
        @(negedge CLK);
        OP_A = 16'h0100; OP_B = 16'h0200; CIN = 0; SUB = 0; START = 1;
        @(negedge CLK);
        OP_A = 16'h0003; OP_B = 16'h0004;
        lat = 0;
        while (!DONE && lat < 40) begin @(negedge CLK); lat++; end
        check("r033_first", SUM, 16'h0300);
        @(negedge CLK); START = 0;
        gap = 1;
        while (!DONE && gap < 40) begin @(negedge CLK); gap++; end
        check("r033_gap", gap, 5);
        check("r033_second", SUM, 16'h0007);

        // Reset mid-RUN at IDX=2
        @(negedge CLK);
        OP_A = 16'h1234; OP_B = 16'h1111; CIN = 0; SUB = 0; START = 1;
        @(negedge CLK); START = 0;
        @(negedge CLK);
        @(negedge CLK);
        #2 RST_n = 0;
        #1;
        check("r034_rst", {SUM, COUT, OVF, BUSY, DONE}, 0);
        @(negedge CLK); RST_n = 1;
        do_op(16'h000A, 16'h0005, 1, 0, lat, nb);
        check("r034_after", {COUT, SUM}, {1'b0, 16'h0010});
        check("r034_lat", lat, 4);

        // NIB=1 instance
        @(negedge CLK);
        a1 = 4'hF; b1 = 4'h1; cin1 = 0; sub1 = 0; start1 = 1;
        @(negedge CLK); start1 = 0;
        lat = 0;
        while (!done1 && lat < 40) begin @(negedge CLK); lat++; end
        check("r035_lat", lat, 1);
        check("r035_res", {cout1, ovf1, sum1}, {2'b10, 4'h0});

        // Randomised traffic, checked by the compare process
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            START = ($urandom_range(0, 2) == 0);
            OP_A = 16'($urandom); OP_B = 16'($urandom);
            CIN = 1'($urandom); SUB = 1'($urandom);
        end
        @(negedge CLK); START = 0;
        repeat (10) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
